multi_timer: RTL

Parametrised, memory-mapped timer block providing `CHANNELS` independent 32-bit up-counting timers on the shared data bus. Each channel has its own prescaler, reload/compare value, periodic or one-shot mode and interrupt enable. A shared status register latches channel events, and one `irq` output is driven toward the core. It complements the fixed millisecond systick by giving software programmable delays and periodic events.

---
 rtl/multi_timer_pkg.sv | 27 ++
 rtl/multi_timer_if.sv | 10 +
 rtl/timer_channel.sv | 95 +++++++++
 rtl/multi_timer.sv | 101 ++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - register map, control bit and bus mode constants for multi_timer
package multi_timer_pkg;

    localparam logic [31:0] CTRL_OFS   = 32'h0;
    localparam logic [31:0] PRESC_OFS  = 32'h4;
    localparam logic [31:0] RELOAD_OFS = 32'h8;
    localparam logic [31:0] COUNT_OFS  = 32'hC;
    localparam logic [31:0] STATUS_OFS = 32'h40;
    localparam logic [31:0] CH_STRIDE  = 32'h10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    // Word index inside a channel's 16-byte window
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESC  = 2'd1,
        REG_RELOAD = 2'd2,
        REG_COUNT  = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - address/mode side of the shared data bus
interface multi_timer_if;

    logic [31:0] addr;
    logic [1:0]  mode;

    modport master (output addr, output mode);
    modport slave  (input addr, input mode);

endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one 32-bit up-counting timer with prescaler, reload compare and one-shot/periodic mode
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter logic [31:0] PRESCALER_RESET = 32'd16499
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  reg_sel_e    wr_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] ctrl_rd,
    output logic [31:0] presc_rd,
    output logic [31:0] reload_rd,
    output logic [31:0] count_rd,
    output logic        evt
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic [31:0] presc_val_q, presc_val_d;
    logic        count_wr;

    assign count_wr = wr_en && (wr_sel == REG_COUNT);

    always_comb begin
        ctrl_d      = ctrl_q;
        presc_d     = presc_q;
        reload_d    = reload_q;
        count_d     = count_q;
        presc_val_d = presc_val_q;
        evt         = 1'b0;

        if (ctrl_q[CTRL_EN]) begin
            if (presc_val_q >= presc_q) begin
                presc_val_d = '0;
                // A COUNT write on the same edge replaces the tick outcome entirely
                if ((count_q >= reload_q) && !count_wr) begin
                    evt = 1'b1;
                    if (ctrl_q[CTRL_PERIODIC]) begin
                        count_d = '0;
                    end else begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end
                end else begin
                    count_d = count_q + 32'd1;
                end
            end else begin
                presc_val_d = presc_val_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (wr_sel)
                REG_CTRL: begin
                    ctrl_d = wr_data[2:0];
                    if (!ctrl_q[CTRL_EN] && wr_data[CTRL_EN]) begin
                        presc_val_d = '0;
                        count_d     = '0;
                    end
                end
                REG_PRESC:  presc_d  = wr_data;
                REG_RELOAD: reload_d = wr_data;
                REG_COUNT: begin
                    count_d     = wr_data;
                    presc_val_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            presc_q     <= PRESCALER_RESET;
            reload_q    <= '0;
            count_q     <= '0;
            presc_val_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_q     <= presc_d;
            reload_q    <= reload_d;
            count_q     <= count_d;
            presc_val_q <= presc_val_d;
        end
    end

    assign ctrl_rd   = {29'd0, ctrl_q};
    assign presc_rd  = presc_q;
    assign reload_rd = reload_q;
    assign count_rd  = count_q;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - memory-mapped multi-channel timer: decode, status/pending, read mux, tri-state and irq
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h4020,
    parameter int          CHANNELS        = 2,
    parameter logic [31:0] PRESCALER_RESET = 32'd16499
) (
    input  logic         clk,
    input  logic         reset,
    multi_timer_if.slave data_bus,
    inout  wire  [31:0]  data_bus_data,
    output logic         irq
);

    logic [31:0]         ofs;
    logic                ch_hit;
    logic                status_hit;
    logic                wr_req;
    logic                rd_oe;
    logic [1:0]          ch_idx;
    reg_sel_e            sel;
    logic [31:0]         rd_data;
    logic [CHANNELS-1:0] ch_wr;
    logic [CHANNELS-1:0] evt_vec;
    logic [CHANNELS-1:0] ie_vec;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [31:0]         ctrl_rd   [CHANNELS];
    logic [31:0]         presc_rd  [CHANNELS];
    logic [31:0]         reload_rd [CHANNELS];
    logic [31:0]         count_rd  [CHANNELS];

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside the channel window
    assign ofs        = data_bus.addr - BASE_ADDR;
    assign ch_hit     = (ofs < (32'(CHANNELS) * CH_STRIDE)) && (ofs[1:0] == 2'b00);
    assign status_hit = (data_bus.addr == (BASE_ADDR + STATUS_OFS));
    assign ch_idx     = ofs[5:4];
    assign sel        = reg_sel_e'(ofs[3:2]);
    assign wr_req     = (data_bus.mode == MODE_WRITE);
    assign rd_oe      = (data_bus.mode == MODE_READ) && (ch_hit || status_hit);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign ch_wr[n] = wr_req && ch_hit && (ch_idx == 2'(n));

        timer_channel #(
            .PRESCALER_RESET(PRESCALER_RESET)
        ) u_timer_channel (
            .clk      (clk),
            .rst_n    (reset),
            .wr_en    (ch_wr[n]),
            .wr_sel   (sel),
            .wr_data  (data_bus_data),
            .ctrl_rd  (ctrl_rd[n]),
            .presc_rd (presc_rd[n]),
            .reload_rd(reload_rd[n]),
            .count_rd (count_rd[n]),
            .evt      (evt_vec[n])
        );

        assign ie_vec[n] = ctrl_rd[n][CTRL_IE];
    end

    // Event set is applied after the W1C clear so a coincident event is never lost
    always_comb begin
        pending_d = pending_q;
        if (wr_req && status_hit) begin
            pending_d = pending_d & ~data_bus_data[CHANNELS-1:0];
        end
        pending_d = pending_d | evt_vec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (status_hit) begin
            rd_data = 32'(pending_q);
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (ch_hit && (ch_idx == 2'(n))) begin
                    case (sel)
                        REG_CTRL:   rd_data = ctrl_rd[n];
                        REG_PRESC:  rd_data = presc_rd[n];
                        REG_RELOAD: rd_data = reload_rd[n];
                        REG_COUNT:  rd_data = count_rd[n];
                    endcase
                end
            end
        end
    end

    assign data_bus_data = rd_oe ? rd_data : 32'bz;
    assign irq           = |(pending_q & ie_vec);

endmodule
